peripheral_msi_wb_driver: RTL and testbench



---
 rtl/peripheral_msi_wb_driver.sv | 229 ++++++++++++++++++++++
 tb/tb_peripheral_msi_wb_driver.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_msi_wb_driver.sv
// Wishbone master for the 16550-style MSI/UART slave: programs the line and FIFO
// settings after reset, then polls LSR to move bytes between the UART and valid/ready streams.
module peripheral_msi_wb_driver #(
    parameter logic [15:0] DIVISOR  = 16'd27,
    parameter logic [7:0]  LCR_VAL  = 8'h03,
    parameter int          POLL_GAP = 4,
    parameter int          TIMEOUT  = 64
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    output logic [3:0] wb_sel_o,
    input  logic       wb_ack_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       init_done_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        S_INIT,
        S_GAP,
        S_LSR_RD,
        S_RBR_RD,
        S_THR_WR,
        S_HALT
    } state_t;

    localparam int              TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [7:0]      GAP_LOAD = 8'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    // With no poll gap the idle path goes straight back to reading LSR.
    localparam state_t          IDLE_STATE = (POLL_GAP == 0) ? S_LSR_RD : S_GAP;

    localparam logic [2:0] ADR_RBR_THR = 3'd0;
    localparam logic [2:0] ADR_DLM_IER = 3'd1;
    localparam logic [2:0] ADR_FCR     = 3'd2;
    localparam logic [2:0] ADR_LCR     = 3'd3;
    localparam logic [2:0] ADR_LSR     = 3'd5;

    state_t          state_q, state_d;
    logic [2:0]      step_q, step_d;
    logic [7:0]      gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic [3:0]      sel_q, sel_d;
    logic [2:0]      adr_q, adr_d;
    logic [7:0]      dat_q, dat_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            tx_ready_q, tx_ready_d;
    logic            init_done_q, init_done_d;
    logic            err_q, err_d;

    logic [2:0] bus_adr;
    logic       bus_we;
    logic [7:0] bus_dat;

    // Address/data/direction of the transfer owned by the current state.
    always_comb begin : bus_request
        bus_adr = 3'd0;
        bus_we  = 1'b0;
        bus_dat = dat_q;
        case (state_q)
            S_INIT: begin
                bus_we = 1'b1;
                case (step_q)
                    3'd0: begin bus_adr = ADR_LCR;     bus_dat = LCR_VAL | 8'h80; end
                    3'd1: begin bus_adr = ADR_RBR_THR; bus_dat = DIVISOR[7:0];    end
                    3'd2: begin bus_adr = ADR_DLM_IER; bus_dat = DIVISOR[15:8];   end
                    3'd3: begin bus_adr = ADR_LCR;     bus_dat = LCR_VAL & 8'h7F; end
                    3'd4: begin bus_adr = ADR_FCR;     bus_dat = 8'h07;           end
                    default: begin bus_adr = ADR_DLM_IER; bus_dat = 8'h00;       end
                endcase
            end
            S_LSR_RD: bus_adr = ADR_LSR;
            S_RBR_RD: bus_adr = ADR_RBR_THR;
            S_THR_WR: begin
                bus_adr = ADR_RBR_THR;
                bus_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin : next_state
        state_d     = state_q;
        step_d      = step_q;
        gap_cnt_d   = gap_cnt_q;
        to_cnt_d    = '0;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ready_i;
        tx_ready_d  = 1'b0;
        init_done_d = init_done_q;
        err_d       = err_q;

        case (state_q)
            S_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = S_LSR_RD;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            S_HALT: ;
            default: begin
                if (!cyc_q) begin
                    // Every bus state enters with the bus idle; open its cycle now.
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    adr_d = bus_adr;
                    we_d  = bus_we;
                    dat_d = bus_dat;
                end else if (wb_ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    case (state_q)
                        S_INIT: begin
                            if (step_q == 3'd5) begin
                                init_done_d = 1'b1;
                                state_d     = IDLE_STATE;
                                gap_cnt_d   = GAP_LOAD;
                            end else begin
                                step_d = step_q + 3'd1;
                            end
                        end
                        S_LSR_RD: begin
                            // Draining RX wins over TX so the receive FIFO cannot overrun.
                            if (wb_dat_i[0] && !rx_valid_q) begin
                                state_d = S_RBR_RD;
                            end else if (wb_dat_i[5] && tx_valid_i) begin
                                state_d = S_THR_WR;
                                dat_d   = tx_data_i;
                            end else begin
                                state_d   = IDLE_STATE;
                                gap_cnt_d = GAP_LOAD;
                            end
                        end
                        S_RBR_RD: begin
                            rx_data_d  = wb_dat_i;
                            rx_valid_d = 1'b1;
                            state_d    = S_LSR_RD;
                        end
                        S_THR_WR: begin
                            tx_ready_d = 1'b1;
                            state_d    = IDLE_STATE;
                            gap_cnt_d  = GAP_LOAD;
                        end
                        default: ;
                    endcase
                end else if (to_cnt_q == TO_LAST) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
        endcase

        sel_d = cyc_d ? 4'b0001 : 4'b0000;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_INIT;
            step_q      <= 3'd0;
            gap_cnt_q   <= 8'd0;
            to_cnt_q    <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'b0000;
            adr_q       <= 3'd0;
            dat_q       <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_ready_q  <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            gap_cnt_q   <= gap_cnt_d;
            to_cnt_q    <= to_cnt_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_ready_q  <= tx_ready_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
        end
    end

    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_we_o     = we_q;
    assign wb_stb_o    = stb_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_sel_o    = sel_q;
    assign tx_ready_o  = tx_ready_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign init_done_o = init_done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_peripheral_msi_wb_driver.sv
// Bench for peripheral_msi_wb_driver: a zero-wait UART slave model with scripted LSR/RBR
// responses, a transfer log, directed poll vectors and hand-written multi-cycle sequences.
module tb_peripheral_msi_wb_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
    logic [3:0] wb_sel_o;
    logic [7:0] tx_data_i, rx_data_o;
    logic       tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i, init_done_o, err_o;

    always #5 clk = ~clk;

    peripheral_msi_wb_driver dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_we_o    (wb_we_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_sel_o   (wb_sel_o),
        .wb_ack_i   (wb_ack_i),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .init_done_o(init_done_o),
        .err_o      (err_o)
    );

    typedef struct {
        logic [2:0] adr;
        logic       we;
        logic [7:0] dat;
        bit         tag;
        int         cyc;
    } xfer_t;

    typedef struct {
        logic [7:0] lsr;
        logic [7:0] rbr;
        logic       rx_ready;
        logic       tx_valid;
        logic [7:0] tx_data;
        logic [2:0] exp_adr;
        logic       exp_we;
        logic [7:0] exp_dat;
        int         exp_txr;
        logic [7:0] exp_rx;
        logic       exp_rxv;
    } vec_t;

    xfer_t      xlog[$];
    logic [7:0] lsr_q[$];
    logic [7:0] rbr_q[$];
    logic [7:0] rx_seen[$];
    int         ack_limit = -1;
    logic       ack_r = 1'b0;
    logic [7:0] rdat = 8'h00;
    bit         tag_r = 1'b0;
    int         cycle_no = 0;
    int         txr_hi = 0, rx_hi = 0, sel_err = 0;
    logic [7:0] last_rx = 8'h00;
    logic       rxv_prev = 1'b0;
    int         checks = 0, failures = 0;

    assign wb_ack_i = ack_r;
    assign wb_dat_i = rdat;

    // Zero-wait slave: ack one cycle after stb, LSR/RBR data from scripted queues.
    always @(posedge clk) begin
        if (rst) begin
            ack_r <= 1'b0;
        end else if (wb_cyc_o && wb_stb_o && !ack_r && (ack_limit < 0 || xlog.size() < ack_limit)) begin
            ack_r <= 1'b1;
            tag_r <= 1'b0;
            rdat  <= 8'h00;
            if (!wb_we_o && wb_adr_o == 3'd5) begin
                if (lsr_q.size() > 0) begin
                    rdat  <= lsr_q.pop_front();
                    tag_r <= 1'b1;
                end
            end else if (!wb_we_o && wb_adr_o == 3'd0) begin
                if (rbr_q.size() > 0) rdat <= rbr_q.pop_front();
                else rdat <= 8'hEE;
            end
        end else begin
            ack_r <= 1'b0;
        end
    end

    always @(posedge clk) begin
        cycle_no = cycle_no + 1;
        if (!rst && wb_cyc_o && wb_stb_o && ack_r)
            xlog.push_back('{wb_adr_o, wb_we_o, wb_we_o ? wb_dat_o : rdat, tag_r, cycle_no});
    end

    always @(negedge clk) begin
        if (tx_ready_o) txr_hi = txr_hi + 1;
        if (rx_valid_o) begin
            rx_hi   = rx_hi + 1;
            last_rx = rx_data_o;
            if (!rxv_prev) rx_seen.push_back(rx_data_o);
        end
        rxv_prev = rx_valid_o;
        if (wb_sel_o != (wb_cyc_o ? 4'b0001 : 4'b0000)) sel_err = sel_err + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_expired(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=wait_expired required=event", name);
    endtask

    function automatic logic [29:0] outs();
        return {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
                rx_data_o, rx_valid_o, tx_ready_o, init_done_o, err_o};
    endfunction

    function automatic int find_tag();
        foreach (xlog[i]) if (xlog[i].tag) return i;
        return -1;
    endfunction

    task automatic wait_after_tag(input int n, output int idx);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            idx = find_tag();
            if (idx >= 0 && xlog.size() > idx + n) return;
        end
        idx = -1;
    endtask

    task automatic check_init(input string name);
        logic [11:0] exp_init[6];
        exp_init = '{{3'd3, 1'b1, 8'h83}, {3'd0, 1'b1, 8'h1B}, {3'd1, 1'b1, 8'h00},
                     {3'd3, 1'b1, 8'h03}, {3'd2, 1'b1, 8'h07}, {3'd1, 1'b1, 8'h00}};
        if (xlog.size() < 6) begin
            wait_expired({name, "_count"});
            return;
        end
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_step%0d", name, i + 1), {xlog[i].adr, xlog[i].we, xlog[i].dat}, exp_init[i]);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [11:0] exp_seq[5];
        int          idx, base_txr, base_rxh, base_seen, cnt;

        vecs[0] = '{8'h01, 8'hA5, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 8'hA5, 0, 8'hA5, 1'b0};
        vecs[1] = '{8'h20, 8'h00, 1'b1, 1'b1, 8'h3C, 3'd0, 1'b1, 8'h3C, 1, 8'hA5, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h3C, 3'd5, 1'b0, 8'h00, 0, 8'hA5, 1'b0};
        vecs[3] = '{8'h21, 8'h77, 1'b1, 1'b1, 8'h99, 3'd0, 1'b0, 8'h77, 0, 8'h77, 1'b0};
        vecs[4] = '{8'h61, 8'hC3, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'hC3, 0, 8'hC3, 1'b1};
        vecs[5] = '{8'h01, 8'h11, 1'b0, 1'b0, 8'h00, 3'd5, 1'b0, 8'h00, 0, 8'hC3, 1'b1};
        vecs[6] = '{8'h01, 8'h22, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 8'h22, 0, 8'h22, 1'b0};
        vecs[7] = '{8'h40, 8'h00, 1'b1, 1'b1, 8'h5E, 3'd5, 1'b0, 8'h00, 0, 8'h22, 1'b0};

        rst = 1'b1; tx_data_i = 8'h00; tx_valid_i = 1'b0; rx_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(outs()), 32'd0);
        xlog.delete();
        rst = 1'b0;

        // Init sequence with a zero-wait slave
        idx = 0;
        for (int k = 0; k < 200 && !init_done_o; k++) @(negedge clk);
        if (!init_done_o) wait_expired("init_done_wait");
        else begin
            check_init("init");
            chk("init_done_latency", cycle_no, xlog[5].cyc);
            chk("transfer_period", xlog[1].cyc - xlog[0].cyc, 3);
            chk("init_err", err_o, 1'b0);
        end
        repeat (10) @(negedge clk);

        // Single-poll vectors: the transfer that follows the scripted LSR read
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            rx_ready_i = vecs[v].rx_ready;
            tx_valid_i = vecs[v].tx_valid;
            tx_data_i  = vecs[v].tx_data;
            rbr_q.delete(); lsr_q.delete(); xlog.delete();
            rbr_q.push_back(vecs[v].rbr);
            base_txr = txr_hi;
            lsr_q.push_back(vecs[v].lsr);
            wait_after_tag(1, idx);
            if (idx < 0) wait_expired($sformatf("vec%0d_wait", v));
            else begin
                repeat (3) @(negedge clk);
                chk($sformatf("vec%0d_next_xfer", v), {xlog[idx+1].adr, xlog[idx+1].we, xlog[idx+1].dat},
                    {vecs[v].exp_adr, vecs[v].exp_we, vecs[v].exp_dat});
                chk($sformatf("vec%0d_tx_ready_cycles", v), txr_hi - base_txr, vecs[v].exp_txr);
                chk($sformatf("vec%0d_rx_data", v), last_rx, vecs[v].exp_rx);
                chk($sformatf("vec%0d_rx_valid", v), rx_valid_o, vecs[v].exp_rxv);
            end
            tx_valid_i = 1'b0;
            repeat (12) @(negedge clk);
        end

        // RX drain: two back-to-back RBR reads, one-cycle valids, no THR write
        @(negedge clk);
        rx_ready_i = 1'b1; tx_valid_i = 1'b0;
        rbr_q.delete(); lsr_q.delete(); xlog.delete();
        base_rxh = rx_hi; base_seen = rx_seen.size();
        rbr_q.push_back(8'hA5); rbr_q.push_back(8'h5A);
        lsr_q.push_back(8'h01); lsr_q.push_back(8'h01); lsr_q.push_back(8'h60);
        exp_seq = '{{3'd5, 1'b0, 8'h01}, {3'd0, 1'b0, 8'hA5}, {3'd5, 1'b0, 8'h01},
                    {3'd0, 1'b0, 8'h5A}, {3'd5, 1'b0, 8'h60}};
        wait_after_tag(4, idx);
        if (idx < 0) wait_expired("drain_wait");
        else begin
            repeat (6) @(negedge clk);
            for (int i = 0; i < 5; i++)
                chk($sformatf("drain_xfer%0d", i), {xlog[idx+i].adr, xlog[idx+i].we, xlog[idx+i].dat}, exp_seq[i]);
            chk("drain_valid_cycles", rx_hi - base_rxh, 2);
            if (rx_seen.size() >= base_seen + 2) begin
                chk("drain_byte0", rx_seen[base_seen], 8'hA5);
                chk("drain_byte1", rx_seen[base_seen+1], 8'h5A);
            end else wait_expired("drain_bytes");
            cnt = 0;
            foreach (xlog[i]) if (xlog[i].we) cnt++;
            chk("drain_no_write", cnt, 0);
        end
        repeat (10) @(negedge clk);

        // Priority: RBR read, then LSR poll, then THR write
        @(negedge clk);
        rx_ready_i = 1'b1; tx_valid_i = 1'b1; tx_data_i = 8'h3C;
        rbr_q.delete(); lsr_q.delete(); xlog.delete();
        base_txr = txr_hi;
        rbr_q.push_back(8'h5D);
        lsr_q.push_back(8'h21); lsr_q.push_back(8'h20);
        exp_seq = '{{3'd5, 1'b0, 8'h21}, {3'd0, 1'b0, 8'h5D}, {3'd5, 1'b0, 8'h20},
                    {3'd0, 1'b1, 8'h3C}, {3'd5, 1'b0, 8'h00}};
        wait_after_tag(3, idx);
        if (idx < 0) wait_expired("priority_wait");
        else begin
            repeat (3) @(negedge clk);
            for (int i = 0; i < 4; i++)
                chk($sformatf("priority_xfer%0d", i), {xlog[idx+i].adr, xlog[idx+i].we, xlog[idx+i].dat}, exp_seq[i]);
            chk("priority_tx_ready_cycles", txr_hi - base_txr, 1);
        end
        tx_valid_i = 1'b0;
        repeat (10) @(negedge clk);

        // Reset mid-cycle while an RX byte is held
        @(negedge clk);
        rx_ready_i = 1'b0;
        rbr_q.delete(); lsr_q.delete();
        rbr_q.push_back(8'h9A); lsr_q.push_back(8'h01);
        for (int k = 0; k < 200 && !rx_valid_o; k++) @(negedge clk);
        for (int k = 0; k < 200 && !wb_cyc_o; k++) @(negedge clk);
        if (!(rx_valid_o && wb_cyc_o)) wait_expired("midreset_setup");
        #2 rst = 1'b1;
        #1 chk("midreset_outputs", 32'(outs()), 32'd0);
        @(negedge clk);
        rbr_q.delete(); lsr_q.delete(); xlog.delete();
        rst = 1'b0;
        for (int k = 0; k < 200 && xlog.size() < 6; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_init("reinit");
        chk("reinit_done", init_done_o, 1'b1);
        chk("reinit_rx_lost", rx_valid_o, 1'b0);
        rx_ready_i = 1'b1;
        repeat (5) @(negedge clk);

        // Timeout at init step 3
        @(negedge clk);
        rst = 1'b1; ack_limit = 2;
        @(negedge clk);
        xlog.delete(); lsr_q.delete();
        rst = 1'b0;
        for (int k = 0; k < 100 && xlog.size() < 2; k++) @(negedge clk);
        if (xlog.size() < 2) wait_expired("timeout_setup");
        cnt = 0;
        for (int k = 0; k < 300 && !err_o; k++) begin
            @(negedge clk);
            if (!err_o && wb_cyc_o) cnt++;
        end
        chk("timeout_err", err_o, 1'b1);
        chk("timeout_cycles", cnt, 64);
        chk("timeout_cyc_dropped", wb_cyc_o, 1'b0);
        chk("timeout_init_done", init_done_o, 1'b0);
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (wb_cyc_o || wb_stb_o) cnt++;
        end
        chk("halt_no_cycles", cnt, 0);
        chk("halt_err_sticky", err_o, 1'b1);
        chk("sel_tracks_cyc", sel_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
